pipe_skid_reg: RTL and testbench

- Parametrised pipeline stage register for the 8-bit core; it is the next generation of the fixed inter-stage registers.
- Payload and control buses are generic; control is the write-enable / mux-select class of fields.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput with a registered in_ready), and synchronous flush that inserts a bubble.
- Sits between any two pipeline stages (EX/MEM, MEM/WB); upstream stalls come from downstream backpressure.

---
 rtl/pipe_skid_reg.sv | 99 +++++++++
 tb/tb_pipe_skid_reg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer and synchronous flush.
// Control fields are zeroed whenever no valid beat is presented, so bubbles never write downstream.
module pipe_skid_reg #(
    parameter int DATA_W = 40,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // State encoding equals the number of held beats, so occupancy is the state register itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_push;
    logic w_pop;

    assign w_push = in_valid && (r_state != ST_FULL);
    assign w_pop  = (r_state != ST_EMPTY) && out_ready;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values;
    // the payload registers are few and explicitly cleared on reset so nothing leaves reset as X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            // Kill held beats and any beat offered this cycle; payload left as don't-care.
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end else if (w_push) begin
                        r_skid_data <= in_data;
                        r_skid_ctrl <= in_ctrl;
                        r_state     <= ST_FULL;
                    end else if (w_pop) begin
                        r_main_ctrl <= '0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                        r_skid_ctrl <= '0;
                        r_state     <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_main_ctrl <= '0;
                    r_skid_ctrl <= '0;
                end
            endcase
        end
    end

    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = (r_state != ST_FULL);
    assign occupancy = r_state;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: table of per-cycle vectors plus hand sequences for async reset.
module tb_pipe_skid_reg;

    localparam int DATA_W = 40;
    localparam int CTRL_W = 3;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    int n_cmp = 0;
    int n_err = 0;

    pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              iv;
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        logic              fl;
        logic              ordy;
        logic              e_ov;
        logic [DATA_W-1:0] e_d;
        logic [CTRL_W-1:0] e_c;
        logic              e_ir;
        logic [1:0]        e_occ;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic iv, logic [DATA_W-1:0] d, logic [CTRL_W-1:0] c, logic fl,
                                logic ordy, logic e_ov, logic [DATA_W-1:0] e_d,
                                logic [CTRL_W-1:0] e_c, logic e_ir, logic [1:0] e_occ);
        vec_t v;
        v.iv = iv; v.d = d; v.c = c; v.fl = fl; v.ordy = ordy;
        v.e_ov = e_ov; v.e_d = e_d; v.e_c = e_c; v.e_ir = e_ir; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_ov, input logic [DATA_W-1:0] e_d,
                              input logic [CTRL_W-1:0] e_c, input logic e_ir, input logic [1:0] e_occ);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
        check({tag, ".out_ctrl"},  64'(out_ctrl),  64'(e_c));
        check({tag, ".in_ready"},  64'(in_ready),  64'(e_ir));
        check({tag, ".occupancy"}, 64'(occupancy), 64'(e_occ));
        if (e_ov) check({tag, ".out_data"}, 64'(out_data), 64'(e_d));
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic fl, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            iv  data   ctrl fl rdy   ov  e_data e_ctrl ir occ
        // streaming 0x01..0x05 with out_ready held high
        vecs[0]  = mk(1, 'h01, 3'd1, 0, 1,   1, 'h01, 3'd1, 1, 2'd1);
        vecs[1]  = mk(1, 'h02, 3'd2, 0, 1,   1, 'h02, 3'd2, 1, 2'd1);
        vecs[2]  = mk(1, 'h03, 3'd3, 0, 1,   1, 'h03, 3'd3, 1, 2'd1);
        vecs[3]  = mk(1, 'h04, 3'd4, 0, 1,   1, 'h04, 3'd4, 1, 2'd1);
        vecs[4]  = mk(1, 'h05, 3'd5, 0, 1,   1, 'h05, 3'd5, 1, 2'd1);
        vecs[5]  = mk(0, 'h00, 3'd0, 0, 1,   0, 'h00, 3'd0, 1, 2'd0);
        // backpressure: A then B fill both entries, stall holds A stable
        vecs[6]  = mk(1, 'h11, 3'd1, 0, 0,   1, 'h11, 3'd1, 1, 2'd1);
        vecs[7]  = mk(1, 'h22, 3'd2, 0, 0,   1, 'h11, 3'd1, 0, 2'd2);
        vecs[8]  = mk(1, 'h99, 3'd7, 0, 0,   1, 'h11, 3'd1, 0, 2'd2);
        vecs[9]  = mk(0, 'h00, 3'd0, 0, 1,   1, 'h22, 3'd2, 1, 2'd1);
        vecs[10] = mk(0, 'h00, 3'd0, 0, 1,   0, 'h00, 3'd0, 1, 2'd0);
        // simultaneous push/pop in ONE
        vecs[11] = mk(1, 'h33, 3'd3, 0, 0,   1, 'h33, 3'd3, 1, 2'd1);
        vecs[12] = mk(1, 'h44, 3'd4, 0, 1,   1, 'h44, 3'd4, 1, 2'd1);
        // drain, then bubble after a ctrl=101 beat
        vecs[13] = mk(0, 'h00, 3'd0, 0, 1,   0, 'h00, 3'd0, 1, 2'd0);
        vecs[14] = mk(1, 'h55, 3'd5, 0, 0,   1, 'h55, 3'd5, 1, 2'd1);
        vecs[15] = mk(0, 'h00, 3'd0, 0, 1,   0, 'h00, 3'd0, 1, 2'd0);
        // flush while FULL with a beat offered; nothing reappears afterwards
        vecs[16] = mk(1, 'hA1, 3'd1, 0, 0,   1, 'hA1, 3'd1, 1, 2'd1);
        vecs[17] = mk(1, 'hA2, 3'd2, 0, 0,   1, 'hA1, 3'd1, 0, 2'd2);
        vecs[18] = mk(1, 'hA3, 3'd7, 1, 0,   0, 'h00, 3'd0, 1, 2'd0);
        vecs[19] = mk(0, 'h00, 3'd0, 0, 1,   0, 'h00, 3'd0, 1, 2'd0);
        vecs[20] = mk(1, 'hB1, 3'd6, 0, 1,   1, 'hB1, 3'd6, 1, 2'd1);
        vecs[21] = mk(0, 'h00, 3'd0, 0, 1,   0, 'h00, 3'd0, 1, 2'd0);
        // flush in EMPTY discards the offered beat
        vecs[22] = mk(1, 'hC1, 3'd7, 1, 1,   0, 'h00, 3'd0, 1, 2'd0);

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check_outs("reset", 1'b0, '0, '0, 1'b1, 2'd0);
        check("reset.out_data", 64'(out_data), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].fl, vecs[i].ordy);
            check_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_d, vecs[i].e_c,
                       vecs[i].e_ir, vecs[i].e_occ);
        end

        // Async reset while FULL with a beat still offered: clears without a clock edge.
        drive(1, 'hE1, 3'd5, 0, 0);
        drive(1, 'hE2, 3'd6, 0, 0);
        check_outs("prefull", 1'b1, 'hE1, 3'd5, 1'b0, 2'd2);
        #2;
        rst = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, '0, '0, 1'b1, 2'd0);
        check("async_rst.out_data", 64'(out_data), 64'h0);
        @(posedge clk);
        #1;
        check_outs("rst_held", 1'b0, '0, '0, 1'b1, 2'd0);

        // First push after release is accepted normally.
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 'hF1;
        in_ctrl   = 3'd3;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post_rst_push", 1'b1, 'hF1, 3'd3, 1'b1, 2'd1);
        drive(0, 'h00, 3'd0, 0, 1);
        check_outs("post_rst_drain", 1'b0, '0, '0, 1'b1, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
